// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction fetch stage in front of the 16-bit unified RAM.
//             The PC drives the RAM read address, and the word comes back
//             combinationally in the same cycle. Each fetched word is stored
//             with its PC in a small prefetch queue. The queue head goes to
//             decode over a valid/ready handshake. A branch redirect flushes
//             the queue and reloads the PC.
//  Options  : define FETCH_PERF_EN to build the saturating fetch/stall
//             performance counters; otherwise both outputs are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        mem_grant,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic [15:0] fetch_count,
    output logic [15:0] stall_count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(QDEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_pc;
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;
    logic [CW-1:0]   r_count;
    logic [15:0]     r_q_pc   [QDEPTH];
    logic [15:0]     r_q_data [QDEPTH];
    logic            w_enq;
    logic            w_deq;

    // The redirect has top priority. Enqueue is also blocked whenever the queue is full.
    // There is no bypass, so a dequeue in the same cycle does not free the slot early.
    assign w_enq = (r_state == RUN) && fetch_en && mem_grant &&
                   (r_count != C_FULL) && !redirect_valid;
    assign w_deq = instr_valid && instr_ready && !redirect_valid;

    assign mem_addr    = r_pc;
    assign instr_valid = (r_count != '0);
    assign instr       = r_q_data[r_rd];
    assign instr_pc    = r_q_pc[r_rd];

    // State register: fetch_en selects RUN or IDLE on every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic. A redirect leaves the run/idle state unchanged.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (fetch_en)  w_state_nxt = RUN;
            RUN:     if (!fetch_en) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // PC, pointers, occupancy and queue storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_pc[i]   <= '0;
                r_q_data[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_q_pc[r_wr]   <= r_pc;
                r_q_data[r_wr] <= mem_rdata;
                r_wr           <= r_wr + 1'b1;
                r_pc           <= r_pc + 16'd1;
            end
            if (w_deq) r_rd <= r_rd + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] r_fetch_count;
    logic [15:0] r_stall_count;

    // Saturating counters. A stall is a RUN cycle with no enqueue, and redirect cycles are excluded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_enq && (r_fetch_count != 16'hFFFF))
                r_fetch_count <= r_fetch_count + 16'd1;
            if ((r_state == RUN) && !w_enq && !redirect_valid &&
                (r_stall_count != 16'hFFFF))
                r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`else
    assign fetch_count = 16'h0000;
    assign stall_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Self-checking bench for fetch_queue. A queue-based reference
//             model is compared against the DUT on every falling edge. Directed
//             literal checks pin down the key points of each scenario.
//             The FETCH_PERF_EN expectations follow the same macro.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

    localparam int          QD  = 4;
    localparam logic [15:0] RPC = 16'h0000;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        mem_grant;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] fetch_count;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;

    // RAM image: words 0..3 hold A000..A003; every other address holds addr^C3C3.
    function automatic logic [15:0] ram(input logic [15:0] a);
        if (a < 16'd4) return 16'hA000 + a;
        return a ^ 16'hC3C3;
    endfunction

    assign mem_rdata = ram(mem_addr);

    fetch_queue #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .mem_grant      (mem_grant),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {pc,word}, a PC, a run flag and the perf counters.
    logic [31:0] mq[$];
    logic [15:0] mpc = RPC;
    logic        mrun = 1'b0;
    logic [15:0] mfc = 16'h0;
    logic [15:0] msc = 16'h0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                mpc  = RPC;
                mrun = 1'b0;
                mfc  = 16'h0;
                msc  = 16'h0;
            end else begin
                logic menq, mdeq;
                menq = mrun && fetch_en && mem_grant && (mq.size() < QD) && !redirect_valid;
                mdeq = (mq.size() != 0) && instr_ready && !redirect_valid;
                if (redirect_valid) begin
                    mq.delete();
                    mpc = redirect_pc;
                end else begin
                    if (mdeq) void'(mq.pop_front());
                    if (menq) begin
                        mq.push_back({mpc, ram(mpc)});
                        mpc = mpc + 16'd1;
                    end
                end
                if (menq) begin
                    if (mfc != 16'hFFFF) mfc = mfc + 16'd1;
                end else if (mrun && !redirect_valid) begin
                    if (msc != 16'hFFFF) msc = msc + 16'd1;
                end
                mrun = fetch_en;
            end
        end
    end

    // Per-cycle comparison against the model, taken away from the active edge.
    always @(negedge clk) begin
        check("valid", {31'd0, instr_valid}, {31'd0, (mq.size() != 0)});
        check("mem_addr", {16'd0, mem_addr}, {16'd0, mpc});
        if (mq.size() != 0) begin
            check("instr", {16'd0, instr}, {16'd0, mq[0][15:0]});
            check("instr_pc", {16'd0, instr_pc}, {16'd0, mq[0][31:16]});
        end
`ifdef FETCH_PERF_EN
        check("fetch_count", {16'd0, fetch_count}, {16'd0, mfc});
        check("stall_count", {16'd0, stall_count}, {16'd0, msc});
`else
        check("fetch_count_tied", {16'd0, fetch_count}, 32'd0);
        check("stall_count_tied", {16'd0, stall_count}, 32'd0);
`endif
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fe, input logic gr, input logic rd,
                         input logic rv, input logic [15:0] rpc);
        fetch_en       = fe;
        mem_grant      = gr;
        instr_ready    = rd;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
        check(name, {16'd0, act}, {16'd0, exp});
    endtask

    logic [15:0] fc_snap, sc_snap;

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        cyc(2);
        rst = 1'b0;
        lit("rst_valid", {15'd0, instr_valid}, 16'd0);
        lit("rst_instr", instr, 16'h0000);
        lit("rst_instr_pc", instr_pc, 16'h0000);
        lit("rst_mem_addr", mem_addr, RPC);
        lit("rst_fetch_count", fetch_count, 16'h0);
        lit("rst_stall_count", stall_count, 16'h0);

        // Basic stream: the first word becomes valid two edges after fetch_en.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        cyc(); lit("t1_valid_lat1", {15'd0, instr_valid}, 16'd0);
        cyc(); lit("t1_valid", {15'd0, instr_valid}, 16'd1);
               lit("t1_i0", instr, 16'hA000); lit("t1_p0", instr_pc, 16'h0000);
        cyc(); lit("t1_i1", instr, 16'hA001); lit("t1_p1", instr_pc, 16'h0001);
        cyc(); lit("t1_i2", instr, 16'hA002);
        cyc(); lit("t1_i3", instr, 16'hA003); lit("t1_p3", instr_pc, 16'h0003);

        // Fill to full with decode stalled, then drain in order.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
        cyc(); lit("t2_flush_valid", {15'd0, instr_valid}, 16'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        cyc(6);
        lit("t2_full_head", instr, 16'hA000);
        lit("t2_full_pc", mem_addr, 16'h0004);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        cyc(); lit("t2_d1", instr, 16'hA001);
        cyc(); lit("t2_d2", instr, 16'hA002);
        cyc(); lit("t2_d3", instr, 16'hA003);
        cyc(); lit("t2_resume_pc", instr_pc, 16'h0004);

        // Redirect while the queue holds three entries.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        cyc(3); lit("t3_three_addr", mem_addr, 16'h0003);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0040);
        cyc(); lit("t3_valid", {15'd0, instr_valid}, 16'd0);
               lit("t3_addr", mem_addr, 16'h0040);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        cyc(); lit("t3_instr", instr, 16'hC383); lit("t3_pc", instr_pc, 16'h0040);

        // Grant toggling: two enqueues and two stalls over four cycles.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0100);
        cyc();
        fc_snap = mfc;
        sc_snap = msc;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0); cyc();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0); cyc();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0); cyc();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0); cyc();
        lit("t4_pc", mem_addr, 16'h0102);
`ifdef FETCH_PERF_EN
        lit("t4_fetch_delta", fetch_count - fc_snap, 16'd2);
        lit("t4_stall_delta", stall_count - sc_snap, 16'd2);
`else
        lit("t4_fetch_off", fetch_count, 16'd0);
        lit("t4_stall_off", stall_count, 16'd0);
`endif

        // PC wrap from FFFF to 0000.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        cyc(2);
        lit("t5_pc_ffff", instr_pc, 16'hFFFF);
        lit("t5_instr_ffff", instr, 16'h3C3C);
        lit("t5_addr", mem_addr, 16'h0001);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        cyc();
        lit("t5_pc_0000", instr_pc, 16'h0000);
        lit("t5_instr_0000", instr, 16'hA000);

        // Asynchronous reset while the queue is full.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        cyc(6);
        lit("t6_pre_addr", mem_addr, 16'h0004);
        rst = 1'b1;
        #1;
        lit("t6_rst_valid", {15'd0, instr_valid}, 16'd0);
        lit("t6_rst_addr", mem_addr, RPC);
        cyc();
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        cyc(); lit("t6_idle_valid", {15'd0, instr_valid}, 16'd0);
        cyc(); lit("t6_restart", instr, 16'hA000);
               lit("t6_restart_pc", instr_pc, 16'h0000);

        // Pause: with fetch_en low the queue keeps draining.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        cyc(4);
        lit("t7_drained", {15'd0, instr_valid}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
